alu_issue_wb: RTL

ALU_ISSUE_WB -- requirements
Module: alu_issue_wb

---
 rtl/alu_issue_wb.sv | 93 +++++++++
 1 files changed

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: two-stage issue/writeback front end around an external combinational ALU
module alu_issue_wb #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3:0]          instr_op,
  input  logic [2:0]          instr_rd,
  input  logic [2:0]          instr_rs1,
  input  logic [2:0]          instr_rs2,
  input  logic                hold,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output logic [3:0]          alu_op,
  input  logic [15:0]         alu_result,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic                wb_valid,
  output logic [2:0]          wb_rd,
  output logic [15:0]         wb_data,
  output logic                flag_carry,
  output logic                flag_zero,
  output logic [RETIRE_W-1:0] retired,
  input  logic [2:0]          dbg_addr,
  output logic [15:0]         dbg_data
);
  logic [15:0] rf [8];
  logic [2:0]  rd_q;
  logic        issue_v;
  logic        accept;
  logic        wr;
  logic [15:0] src_a;
  logic [15:0] src_b;
  assign instr_ready = ~hold;
  assign accept = instr_valid & ~hold;
  assign wr = issue_v & ~hold;
  assign dbg_data = rf[dbg_addr];
  // operand read with bypass of the result being written on this same edge
  always_comb begin
    src_a = (wr && rd_q != 3'd0 && instr_rs1 == rd_q) ? alu_result : rf[instr_rs1];
    src_b = (wr && rd_q != 3'd0 && instr_rs2 == rd_q) ? alu_result : rf[instr_rs2];
  end
  // register file; r0 is never written so it reads zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wr && rd_q != 3'd0) begin
      rf[rd_q] <= alu_result;
    end
  end
  // issue stage: capture operands on accept, drain when idle, freeze under hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      rd_q    <= '0;
      issue_v <= 1'b0;
    end else if (!hold) begin
      issue_v <= instr_valid;
      if (instr_valid) begin
        alu_a  <= src_a;
        alu_b  <= src_b;
        alu_op <= instr_op;
        rd_q   <= instr_rd;
      end
    end
  end
  // writeback stage: flags, retire count and the registered writeback report
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
      retired    <= '0;
    end else begin
      wb_valid <= wr;
      if (wr) begin
        wb_rd      <= rd_q;
        wb_data    <= alu_result;
        flag_carry <= alu_carry;
        flag_zero  <= alu_zero;
        retired    <= retired + 1'b1;
      end
    end
  end
  logic unused_accept;
  assign unused_accept = accept;
endmodule
